// File: rtl/sr_latch_driver_if.sv
// Bundle of request handshake, latch drive and latch readback signals for
// sr_latch_driver. The slave side is the controller, the master side is the
// environment (request source plus the latch itself).
interface sr_latch_driver_if;
    logic req_valid;
    logic req_data;
    logic req_ready;
    logic s_out;
    logic r_out;
    logic q_fb;
    logic qn_fb;
    logic done;
    logic err;

    modport master (
        output req_valid,
        output req_data,
        output q_fb,
        output qn_fb,
        input  req_ready,
        input  s_out,
        input  r_out,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  q_fb,
        input  qn_fb,
        output req_ready,
        output s_out,
        output r_out,
        output done,
        output err
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Synchronous driver for a NOR SR latch: accepts a requested value, issues a
// timed set or reset pulse, reads Q/Qn back and retries on failure. S and R
// are derived from a single pulse flag and one target bit, so S=R=1 cannot
// be produced.
module sr_latch_driver #(
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned SETTLE_W  = 1,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic              clk,
    input logic              rst_n,
    sr_latch_driver_if.slave bus
);

    localparam int unsigned PsMax  = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int unsigned CntMax = (PsMax > MAX_RETRY + 1) ? PsMax : MAX_RETRY + 1;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] PulseLast  = CntW'(PULSE_W - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_W - 1);
    localparam logic [CntW-1:0] RetryMax   = CntW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StInitPulse,
        StIdle,
        StPulse,
        StSettle,
        StVerify,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] retry_q, retry_d;
    logic            target_q, target_d;
    logic            init_q, init_d;

    logic            s_q, r_q, ready_q, done_q, err_q;
    logic            done_d, err_d;
    logic            fb_ok;
    logic            fb_match_req;

    // q_fb == qn_fb never matches, since the target and its inverse differ
    assign fb_ok        = (bus.q_fb == target_q) && (bus.qn_fb == ~target_q);
    assign fb_match_req = (bus.q_fb == bus.req_data) && (bus.qn_fb == ~bus.req_data);

    // Next-state logic for the pulse/settle/verify sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        target_d = target_q;
        init_d   = init_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            StInitPulse: begin
                // Force Q=0 after reset; the outcome is never reported
                state_d  = StPulse;
                target_d = 1'b0;
                init_d   = 1'b1;
                cnt_d    = '0;
                retry_d  = '0;
            end
            StIdle: begin
                if (bus.req_valid) begin
                    target_d = bus.req_data;
                    cnt_d    = '0;
                    if (fb_match_req) begin
                        state_d = StResp;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StPulse;
                    end
                end
            end
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StVerify;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVerify: begin
                if (!fb_ok && (retry_q < RetryMax)) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StPulse;
                end else if (init_q) begin
                    // Init goes to IDLE whether or not the latch verified
                    init_d  = 1'b0;
                    retry_d = '0;
                    state_d = StIdle;
                end else begin
                    state_d = StResp;
                    done_d  = fb_ok;
                    err_d   = ~fb_ok;
                end
            end
            StResp: begin
                retry_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StInitPulse;
            end
        endcase
    end

    // Sequencer state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInitPulse;
            cnt_q    <= '0;
            retry_q  <= '0;
            target_q <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            target_q <= target_d;
            init_q   <= init_d;
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s_q     <= (state_d == StPulse) &&  target_d;
            r_q     <= (state_d == StPulse) && !target_d;
            ready_q <= (state_d == StIdle);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_out     = s_q;
    assign bus.r_out     = r_q;
    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
